// File: rtl/drum_pkg.sv
// drum_pkg: shared constants, FSM encoding and helpers for the drum hit evaluator
package drum_pkg;
  localparam int NUM_CARRILES = 5;
  localparam int Y_W = 10;
  localparam int VENTANA_MIN = 368;
  localparam int VENTANA_MAX = 416;
  localparam int PUNTAJE_W = 16;
  localparam int CNT_W = $clog2(NUM_CARRILES + 1);
  typedef enum logic [1:0] {IDLE, JUGANDO, PERDIDO} estado_t;
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_CARRILES-1:0] v);
    popcount = '0;
    for (int k = 0; k < NUM_CARRILES; k++) popcount = popcount + CNT_W'(v[k]);
  endfunction
endpackage

// File: rtl/evaluador_golpes_if.sv
// evaluador_golpes_if: buttons, note positions and score outputs of the hit evaluator
interface evaluador_golpes_if;
  import drum_pkg::*;
  logic enable;
  logic [NUM_CARRILES-1:0] boton;
  logic [NUM_CARRILES-1:0] nota_activa;
  logic [NUM_CARRILES*Y_W-1:0] nota_y;
  logic [NUM_CARRILES-1:0] acierto;
  logic fallo;
  logic [PUNTAJE_W-1:0] puntaje;
  logic [3:0] fallos;
  logic perdio;
  modport master (output enable, boton, nota_activa, nota_y, input acierto, fallo, puntaje, fallos, perdio);
  modport slave (input enable, boton, nota_activa, nota_y, output acierto, fallo, puntaje, fallos, perdio);
endinterface

// File: rtl/antirrebote.sv
// antirrebote: 2-flop synchronizer, debouncer and rising-edge pulse for one button
module antirrebote #(
  parameter int DEB_CICLOS = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic boton,
  output logic press
);
  localparam int CW = $clog2(DEB_CICLOS + 1);
  logic [1:0] sync;
  logic nivel;
  logic [CW-1:0] cnt;
  // level flips only after the synchronized input differs for DEB_CICLOS cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      nivel <= 1'b0;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      sync <= {sync[0], boton};
      press <= 1'b0;
      if (sync[1] == nivel) cnt <= '0;
      else if (cnt == CW'(DEB_CICLOS - 1)) begin
        nivel <= sync[1];
        cnt <= '0;
        press <= sync[1];
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/evaluador_golpes.sv
// evaluador_golpes: per-lane hit/miss evaluation, saturating score and miss counters, loss FSM
module evaluador_golpes import drum_pkg::*; #(
  parameter int DEB_CICLOS = 500000,
  parameter int MAX_FALLOS = 8
) (
  input logic clk,
  input logic reset,
  evaluador_golpes_if.slave bus
);
  estado_t estado, estado_n;
  logic [NUM_CARRILES-1:0] press, en_ventana, en_prev, golpeada, golpeada_n, salida, hits, misses, acierto;
  logic [PUNTAJE_W:0] suma_p;
  logic [PUNTAJE_W-1:0] puntaje;
  logic [4:0] suma_f;
  logic [3:0] fallos, fallos_n;
  logic fallo, activo, perdio;
  genvar i;
  for (i = 0; i < NUM_CARRILES; i++) begin : g_carril
    antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_ar (.clk(clk), .reset(reset), .boton(bus.boton[i]), .press(press[i]));
  end
  // window detection and event classification; an exiting window still accepts this cycle's press
  always_comb begin
    for (int k = 0; k < NUM_CARRILES; k++)
      en_ventana[k] = bus.nota_activa[k] && bus.nota_y[k*Y_W +: Y_W] >= Y_W'(VENTANA_MIN) && bus.nota_y[k*Y_W +: Y_W] <= Y_W'(VENTANA_MAX);
    salida = en_prev & ~en_ventana;
    hits = activo ? press & (en_ventana | salida) & ~golpeada : '0;
    misses = activo ? (press & ~hits) | (salida & ~golpeada & ~hits) : '0;
    golpeada_n = activo ? (golpeada | hits) & ~salida : '0;
    suma_p = {1'b0, puntaje} + (PUNTAJE_W+1)'(popcount(hits));
    suma_f = 5'(fallos) + 5'(popcount(misses));
    fallos_n = suma_f >= 5'(MAX_FALLOS) ? 4'(MAX_FALLOS) : suma_f[3:0];
  end
  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) estado <= IDLE;
    else estado <= estado_n;
  end
  // FSM next state: loss is taken on the same edge the miss count reaches the limit
  always_comb begin
    estado_n = estado == IDLE ? (bus.enable ? JUGANDO : IDLE) :
               estado == JUGANDO ? (!bus.enable ? IDLE : suma_f >= 5'(MAX_FALLOS) ? PERDIDO : JUGANDO) : PERDIDO;
  end
  // FSM outputs
  always_comb begin
    activo = estado == JUGANDO && bus.enable;
    perdio = estado == PERDIDO;
  end
  // registered pulses, counters and per-lane history
  always_ff @(posedge clk) begin
    if (reset) begin
      en_prev <= '0;
      golpeada <= '0;
      acierto <= '0;
      fallo <= 1'b0;
      puntaje <= '0;
      fallos <= '0;
    end else begin
      en_prev <= en_ventana;
      golpeada <= golpeada_n;
      acierto <= hits;
      fallo <= |misses;
      puntaje <= suma_p[PUNTAJE_W] ? '1 : suma_p[PUNTAJE_W-1:0];
      fallos <= fallos_n;
    end
  end
  assign bus.acierto = acierto;
  assign bus.fallo = fallo;
  assign bus.puntaje = puntaje;
  assign bus.fallos = fallos;
  assign bus.perdio = perdio;
endmodule

// File: tb/tb_evaluador_golpes.sv
// tb_evaluador_golpes: directed stimulus with a scoreboard queue checked by an output monitor
module tb_evaluador_golpes;
  typedef struct packed {
    logic [4:0] ac;
    logic fa;
    logic [15:0] pu;
    logic [3:0] fl;
    logic pe;
  } resp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int lat;
  resp_t q[$];
  resp_t e, a;
  evaluador_golpes_if bus();
  evaluador_golpes #(.DEB_CICLOS(4), .MAX_FALLOS(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic ciclos(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic espera(input logic [4:0] ac, input logic fa, input int pu, input int fl, input logic pe);
    q.push_back('{ac, fa, 16'(pu), 4'(fl), pe});
  endtask
  task automatic nota(input int c, input logic act, input int y);
    bus.nota_activa[c] = act;
    bus.nota_y[c*10 +: 10] = 10'(y);
  endtask
  task automatic golpe(input logic [4:0] m);
    bus.boton = bus.boton | m;
    ciclos(8);
    bus.boton = bus.boton & ~m;
    ciclos(8);
  endtask
  task automatic chk_ceros(input string nm);
    chk({nm, " acierto"}, int'(bus.acierto), 0);
    chk({nm, " fallo"}, int'(bus.fallo), 0);
    chk({nm, " puntaje"}, int'(bus.puntaje), 0);
    chk({nm, " fallos"}, int'(bus.fallos), 0);
    chk({nm, " perdio"}, int'(bus.perdio), 0);
  endtask
  // monitor: every output pulse must match the next queued expectation
  always @(negedge clk) begin
    if (bus.acierto != 0 || bus.fallo) begin
      a = {bus.acierto, bus.fallo, bus.puntaje, bus.fallos, bus.perdio};
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected pulse: acierto=%b fallo=%b puntaje=%0d fallos=%0d perdio=%b", a.ac, a.fa, a.pu, a.fl, a.pe);
      end else begin
        e = q.pop_front();
        if (a != e) begin
          n_fail++;
          $display("FAIL pulse: got acierto=%b fallo=%b puntaje=%0d fallos=%0d perdio=%b, expected acierto=%b fallo=%b puntaje=%0d fallos=%0d perdio=%b",
                   a.ac, a.fa, a.pu, a.fl, a.pe, e.ac, e.fa, e.pu, e.fl, e.pe);
        end
      end
    end
  end
  initial begin
    bus.enable = 1'b0;
    bus.boton = '0;
    bus.nota_activa = '0;
    bus.nota_y = '0;
    ciclos(3);
    reset = 1'b0;
    chk_ceros("reset");
    bus.enable = 1'b1;
    nota(0, 1'b1, 384);
    ciclos(2);
    espera(5'b00001, 1'b0, 1, 0, 1'b0);
    lat = -1;
    bus.boton[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.acierto[0]) begin
        lat = k;
        break;
      end
    end
    chk("latencia acierto", lat, 7);
    ciclos(6);
    bus.boton[0] = 1'b0;
    ciclos(8);
    nota(0, 1'b0, 384);
    ciclos(3);
    nota(0, 1'b1, 384);
    ciclos(2);
    espera(5'b00001, 1'b0, 2, 0, 1'b0);
    bus.boton[0] = 1'b1;
    ciclos(2);
    bus.boton[0] = 1'b0;
    ciclos(1);
    bus.boton[0] = 1'b1;
    ciclos(2);
    bus.boton[0] = 1'b0;
    ciclos(2);
    golpe(5'b00001);
    chk("rebote puntaje", int'(bus.puntaje), 2);
    nota(0, 1'b0, 0);
    ciclos(3);
    chk("salida golpeada fallos", int'(bus.fallos), 0);
    nota(2, 1'b1, 100);
    ciclos(2);
    espera(5'b00000, 1'b1, 2, 1, 1'b0);
    golpe(5'b00100);
    nota(2, 1'b1, 400);
    ciclos(3);
    espera(5'b00000, 1'b1, 2, 2, 1'b0);
    nota(2, 1'b1, 417);
    ciclos(3);
    nota(2, 1'b0, 0);
    ciclos(2);
    chk("escape fallos", int'(bus.fallos), 2);
    nota(1, 1'b1, 368);
    nota(3, 1'b1, 416);
    ciclos(2);
    espera(5'b01010, 1'b0, 4, 2, 1'b0);
    golpe(5'b01010);
    espera(5'b00000, 1'b1, 4, 3, 1'b0);
    golpe(5'b00010);
    nota(1, 1'b0, 0);
    nota(3, 1'b0, 0);
    ciclos(3);
    nota(4, 1'b1, 367);
    ciclos(2);
    espera(5'b00000, 1'b1, 4, 4, 1'b0);
    golpe(5'b10000);
    nota(4, 1'b0, 0);
    ciclos(2);
    chk("borde puntaje", int'(bus.puntaje), 4);
    chk("borde fallos", int'(bus.fallos), 4);
    bus.enable = 1'b0;
    ciclos(2);
    nota(0, 1'b1, 384);
    ciclos(2);
    golpe(5'b00001);
    nota(0, 1'b0, 0);
    ciclos(3);
    chk("pausa puntaje", int'(bus.puntaje), 4);
    chk("pausa fallos", int'(bus.fallos), 4);
    chk("pausa perdio", int'(bus.perdio), 0);
    bus.enable = 1'b1;
    reset = 1'b1;
    ciclos(2);
    reset = 1'b0;
    chk("reinicio puntaje", int'(bus.puntaje), 0);
    chk("reinicio fallos", int'(bus.fallos), 0);
    ciclos(2);
    for (int k = 1; k <= 7; k++) begin
      nota(k % 5, 1'b1, 400);
      ciclos(2);
      espera(5'b00000, 1'b1, 0, k, 1'b0);
      nota(k % 5, 1'b0, 400);
      ciclos(3);
    end
    nota(0, 1'b1, 400);
    nota(1, 1'b1, 400);
    ciclos(2);
    espera(5'b00000, 1'b1, 0, 8, 1'b1);
    nota(0, 1'b0, 0);
    nota(1, 1'b0, 0);
    ciclos(3);
    chk("perdido fallos", int'(bus.fallos), 8);
    chk("perdido perdio", int'(bus.perdio), 1);
    nota(2, 1'b1, 400);
    ciclos(2);
    golpe(5'b00100);
    nota(2, 1'b0, 0);
    ciclos(3);
    chk("congelado puntaje", int'(bus.puntaje), 0);
    chk("congelado fallos", int'(bus.fallos), 8);
    bus.enable = 1'b0;
    ciclos(3);
    bus.enable = 1'b1;
    ciclos(3);
    chk("enable perdio", int'(bus.perdio), 1);
    reset = 1'b1;
    ciclos(2);
    reset = 1'b0;
    chk_ceros("reset final");
    ciclos(2);
    chk("cola vacia", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
